// File: rtl/mem_dump_unit.sv
// Streams every data-memory word (addresses 0 .. 2**W-1) to a UART byte transmitter, most-significant byte first.
// Optional `MEM_DUMP_ADDR_EN: precede each word with a header byte holding its address (W <= 8).
`timescale 1ns/1ps
module mem_dump_unit #(
    parameter int B = 32,
    parameter int W = 5
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic [B-1:0] i_debug_mem,
    input  logic         i_tx_done,
    output logic [W-1:0] o_debug_addr,
    output logic [7:0]   o_tx_data,
    output logic         o_tx_start,
    output logic         o_busy,
    output logic         o_done
);

`ifdef MEM_DUMP_ADDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int NB = B / 8 + HDR;
    localparam int BW = $clog2(NB + 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);
    localparam logic [W-1:0]  LAST_ADDR = {W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t         state_q;
    logic [W-1:0]   addr_q;
    logic [W-1:0]   addr_d;
    logic [BW-1:0]  byte_q;
    logic [BW-1:0]  byte_d;
    logic [B-1:0]   shift_q;
    logic [7:0]     tx_data_q;
    logic           tx_start_q;
    logic           busy_q;
    logic           done_q;

    assign addr_d = addr_q + W'(1);
    assign byte_d = byte_q + BW'(1);

    // shift_q always holds the not-yet-sent bytes left-aligned, so the next byte is its top byte
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            byte_q     <= '0;
            shift_q    <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        addr_q  <= '0;
                        byte_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
`ifdef MEM_DUMP_ADDR_EN
                    tx_data_q <= 8'(addr_q);
                    shift_q   <= i_debug_mem;
`else
                    tx_data_q <= i_debug_mem[B-1 -: 8];
                    shift_q   <= i_debug_mem << 8;
`endif
                    byte_q     <= '0;
                    tx_start_q <= 1'b1;
                    state_q    <= S_SEND;
                end
                S_SEND: begin
                    tx_start_q <= 1'b0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_tx_done) begin
                        if (byte_q == LAST_BYTE) begin
                            state_q <= S_NEXT;
                        end else begin
                            byte_q     <= byte_d;
                            tx_data_q  <= shift_q[B-1 -: 8];
                            shift_q    <= shift_q << 8;
                            tx_start_q <= 1'b1;
                            state_q    <= S_SEND;
                        end
                    end
                end
                S_NEXT: begin
                    if (addr_q == LAST_ADDR) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        addr_q  <= addr_d;
                        state_q <= S_LOAD;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    addr_q  <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_debug_addr = addr_q;
    assign o_tx_data    = tx_data_q;
    assign o_tx_start   = tx_start_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;

endmodule
